// File: rtl/bp_sched_pkg.sv
// Shared types and helpers for the hidden-layer back-propagation scheduler.
// Holds the FSM state type, the IEEE-754 one constant and the counter sizing rule.
package bp_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  localparam logic [31:0] FLOAT_ONE = 32'h3F80_0000;

  // Bits needed to hold every value from 0 up to and including n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bp_tag_fifo.sv
// In-order tag FIFO holding the node index of every request in flight in the datapath.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module bp_tag_fifo
  import bp_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop_s  = pop && (count_r != '0);
  assign do_push_s = push && ((count_r != CNT_FULL) || do_pop_s);
  assign head      = mem_r[rd_ptr_r];
  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == '0);

  // Pointer and occupancy tracking; srst flushes everything at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (srst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (do_pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      count_r <= count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
    end
  end

  // Tag storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/bp_hidden_scheduler.sv
// Time-shares one back-propagation datapath across all hidden nodes of a layer.
// Optional watchdog on a stalled datapath: define BP_SCHED_TIMEOUT_EN.
module bp_hidden_scheduler
  import bp_sched_pkg::*;
#(
  parameter int DATA_WIDTH          = 32,
  parameter int ADDRESS_WIDTH       = 11,
  parameter int NUMBER_OF_BACK_NODE = 32,
  parameter int MAX_OUTSTANDING     = 4,
  parameter int TIMEOUT_CYCLES      = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error,
  output logic                     o_node_rd_en,
  output logic [ADDRESS_WIDTH-1:0] o_node_rd_addr,
  input  logic [DATA_WIDTH-1:0]    i_node_rd_data,
  output logic                     o_dp_valid,
  output logic [ADDRESS_WIDTH-1:0] o_dp_node_addr,
  output logic [DATA_WIDTH-1:0]    o_dp_data_node,
  input  logic                     i_dp_valid,
  input  logic [DATA_WIDTH-1:0]    i_dp_delta,
  output logic                     o_delta_wr_en,
  output logic [ADDRESS_WIDTH-1:0] o_delta_wr_addr,
  output logic [DATA_WIDTH-1:0]    o_delta_wr_data
);

  localparam int CNT_W = cnt_width(NUMBER_OF_BACK_NODE);
  localparam int CRD_W = cnt_width(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] NODES   = CNT_W'(NUMBER_OF_BACK_NODE);
  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(MAX_OUTSTANDING);

  sched_state_e             state_r;
  sched_state_e             state_nxt_s;
  logic [CNT_W-1:0]         rd_cnt_r;
  logic [CNT_W-1:0]         wr_cnt_r;
  logic [CRD_W-1:0]         credits_r;
  logic                     rd_en_r;
  logic [ADDRESS_WIDTH-1:0] rd_addr_r;
  logic                     dp_valid_r;
  logic [ADDRESS_WIDTH-1:0] dp_addr_r;
  logic                     wr_en_r;
  logic [ADDRESS_WIDTH-1:0] wr_addr_r;
  logic [DATA_WIDTH-1:0]    wr_data_r;
  logic                     busy_r;
  logic                     done_r;
  logic                     error_r;
  logic                     start_s;
  logic                     fetch_s;
  logic                     ret_s;
  logic                     spur_s;
  logic                     ovf_s;
  logic                     timeout_s;
  logic                     fifo_full_s;
  logic                     fifo_empty_s;
  logic [ADDRESS_WIDTH-1:0] fifo_head_s;

  assign start_s = (state_r == ST_IDLE) && i_start;
  assign ret_s   = i_dp_valid && !fifo_empty_s;
  assign spur_s  = i_dp_valid && fifo_empty_s;
  assign ovf_s   = dp_valid_r && fifo_full_s && !ret_s;
  // A return in the same cycle frees the credit the new fetch consumes.
  assign fetch_s = (state_r == ST_FETCH) && (rd_cnt_r < NODES) &&
                   ((credits_r < CRD_MAX) || ret_s) && !timeout_s;

`ifdef BP_SCHED_TIMEOUT_EN
  localparam int WD_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt_r;
  logic            wd_arm_s;

  assign wd_arm_s  = ((state_r == ST_FETCH) || (state_r == ST_DRAIN)) &&
                     (credits_r != '0) && !i_dp_valid;
  assign timeout_s = wd_arm_s && (wd_cnt_r == WD_LAST);

  // Watchdog: consecutive cycles with work in flight and nothing returning
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_r <= '0;
    end else if (!wd_arm_s || timeout_s) begin
      wd_cnt_r <= '0;
    end else begin
      wd_cnt_r <= wd_cnt_r + WD_W'(1);
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  bp_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ADDRESS_WIDTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .srst      (start_s | timeout_s),
    .push      (dp_valid_r),
    .push_data (dp_addr_r),
    .pop       (ret_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) state_nxt_s = ST_FETCH;
        else         state_nxt_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (timeout_s)               state_nxt_s = ST_DONE;
        else if (rd_cnt_r == NODES)  state_nxt_s = ST_DRAIN;
        else                         state_nxt_s = ST_FETCH;
      end
      ST_DRAIN: begin
        if (timeout_s || (wr_cnt_r == NODES)) state_nxt_s = ST_DONE;
        else                                  state_nxt_s = ST_DRAIN;
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= (state_nxt_s == ST_DONE);
      if (start_s) error_r <= 1'b0;
      else         error_r <= error_r | spur_s | ovf_s | timeout_s;
    end
  end

  // Fetch side: node RAM strobe, read counter, credits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_r   <= 1'b0;
      rd_addr_r <= '0;
      rd_cnt_r  <= '0;
      credits_r <= '0;
    end else begin
      rd_en_r <= start_s | fetch_s;
      if (start_s) begin
        rd_addr_r <= '0;
        rd_cnt_r  <= CNT_W'(1);
        credits_r <= CRD_W'(1);
      end else begin
        if (fetch_s) rd_addr_r <= ADDRESS_WIDTH'(rd_cnt_r);
        rd_cnt_r <= rd_cnt_r + CNT_W'(fetch_s);
        if (timeout_s) credits_r <= '0;
        else           credits_r <= credits_r + CRD_W'(fetch_s) - CRD_W'(ret_s);
      end
    end
  end

  // Issue to the datapath and write-back of returned deltas
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_valid_r <= 1'b0;
      dp_addr_r  <= '0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
      wr_cnt_r   <= '0;
    end else begin
      dp_valid_r <= rd_en_r & ~timeout_s;
      dp_addr_r  <= rd_addr_r;
      wr_en_r    <= ret_s;
      if (ret_s) begin
        wr_addr_r <= fifo_head_s;
        wr_data_r <= i_dp_delta;
      end
      if (start_s) wr_cnt_r <= '0;
      else         wr_cnt_r <= wr_cnt_r + CNT_W'(ret_s);
    end
  end

  // The node RAM output is already registered; gate it so it reads zero when not issuing.
  assign o_dp_data_node  = dp_valid_r ? i_node_rd_data : '0;
  assign o_busy          = busy_r;
  assign o_done          = done_r;
  assign o_error         = error_r;
  assign o_node_rd_en    = rd_en_r;
  assign o_node_rd_addr  = rd_addr_r;
  assign o_dp_valid      = dp_valid_r;
  assign o_dp_node_addr  = dp_addr_r;
  assign o_delta_wr_en   = wr_en_r;
  assign o_delta_wr_addr = wr_addr_r;
  assign o_delta_wr_data = wr_data_r;

endmodule

// File: tb/tb_bp_hidden_scheduler.sv
// Self-checking bench: a node-RAM model and an in-order random-latency datapath model
// drive the scheduler; every write is compared with the delta expected for that node.
module tb_bp_hidden_scheduler;

  localparam int DW   = 32;
  localparam int AW   = 11;
  localparam int N    = 8;
  localparam int MAXO = 2;
  localparam int TO   = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          o_busy, o_done, o_error;
  logic          o_node_rd_en;
  logic [AW-1:0] o_node_rd_addr;
  logic [DW-1:0] i_node_rd_data = '0;
  logic          o_dp_valid;
  logic [AW-1:0] o_dp_node_addr;
  logic [DW-1:0] o_dp_data_node;
  logic          i_dp_valid = 1'b0;
  logic [DW-1:0] i_dp_delta = '0;
  logic          o_delta_wr_en;
  logic [AW-1:0] o_delta_wr_addr;
  logic [DW-1:0] o_delta_wr_data;

  always #5 clk = ~clk;

  bp_hidden_scheduler #(
    .DATA_WIDTH (DW), .ADDRESS_WIDTH (AW), .NUMBER_OF_BACK_NODE (N),
    .MAX_OUTSTANDING (MAXO), .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk), .rst_n (rst_n), .i_start (i_start),
    .o_busy (o_busy), .o_done (o_done), .o_error (o_error),
    .o_node_rd_en (o_node_rd_en), .o_node_rd_addr (o_node_rd_addr),
    .i_node_rd_data (i_node_rd_data),
    .o_dp_valid (o_dp_valid), .o_dp_node_addr (o_dp_node_addr),
    .o_dp_data_node (o_dp_data_node),
    .i_dp_valid (i_dp_valid), .i_dp_delta (i_dp_delta),
    .o_delta_wr_en (o_delta_wr_en), .o_delta_wr_addr (o_delta_wr_addr),
    .o_delta_wr_data (o_delta_wr_data)
  );

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } iss_t;

  iss_t          dpq[$];
  int            exp_wr_q[$];
  logic [DW-1:0] act [1 << AW];
  int n_checks = 0, n_pass = 0;
  int cyc = 0, t0 = 0;
  int rd_seen, wr_seen, issued, returned, maxout;
  int first_rd, first_iss, second_iss, done_cnt, done_cyc, last_wr, last_due;
  int lat_lo = 1, lat_hi = 1;
  bit stall = 1'b0, no_wr = 1'b0;

  // Behaviour of the datapath: any fixed function of index and activation will do.
  function automatic logic [DW-1:0] dp_fun(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return (d ^ 32'h5A5A_0F0F) + {21'd0, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One clock: observe this cycle's outputs, then drive this cycle's inputs.
  task automatic tick();
    iss_t it;
    int   q;
    @(negedge clk);
    cyc++;
    if (o_node_rd_en) begin
      chk("rd_addr", 32'(o_node_rd_addr), 32'(rd_seen));
      if (first_rd < 0) first_rd = cyc;
      rd_seen++;
      i_node_rd_data = act[o_node_rd_addr];
    end
    if (o_dp_valid) begin
      if (first_iss < 0) first_iss = cyc;
      else if (second_iss < 0) second_iss = cyc;
      it.due = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (it.due <= last_due) it.due = last_due + 1;
      last_due = it.due;
      it.addr = o_dp_node_addr;
      it.data = o_dp_data_node;
      dpq.push_back(it);
      issued++;
    end
    if (o_delta_wr_en) begin
      if (no_wr) begin
        chk("wr_after_abort", 32'(o_delta_wr_en), 32'd0);
      end else begin
        chk("wr_addr", 32'(o_delta_wr_addr), 32'(wr_seen));
        chk("wr_data", o_delta_wr_data, dp_fun(AW'(wr_seen), act[AW'(wr_seen)]));
        q = (exp_wr_q.size() > 0) ? exp_wr_q[0] : -1;
        if (exp_wr_q.size() > 0) exp_wr_q.delete(0);
        chk("wr_latency", 32'(cyc), 32'(q));
        wr_seen++;
        last_wr = cyc;
      end
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    i_dp_valid = 1'b0;
    i_dp_delta = '0;
    if (!stall && dpq.size() > 0 && dpq[0].due <= cyc) begin
      it = dpq.pop_front();
      i_dp_valid = 1'b1;
      i_dp_delta = dp_fun(it.addr, it.data);
      returned++;
      if (!no_wr) exp_wr_q.push_back(cyc + 1);
    end
    if (issued - returned > maxout) maxout = issued - returned;
  endtask

  task automatic begin_run(input int lo, input int hi);
    lat_lo = lo; lat_hi = hi;
    rd_seen = 0; wr_seen = 0; issued = 0; returned = 0; maxout = 0;
    first_rd = -1; first_iss = -1; second_iss = -1;
    done_cnt = 0; done_cyc = -1; last_wr = -1; last_due = cyc; no_wr = 1'b0;
    exp_wr_q.delete();
    dpq.delete();
    for (int i = 0; i < N; i++) act[i] = $urandom();
    t0 = cyc;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("error_clear_on_start", 32'(o_error), 32'd0);
    chk("busy_after_start", 32'(o_busy), 32'd1);
  endtask

  task automatic run(input int lo, input int hi, input bit mid_start);
    begin_run(lo, hi);
    for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
      tick();
      i_start = (mid_start && k == 4) ? 1'b1 : 1'b0;
    end
    chk("done_pulse", 32'(done_cnt), 32'd1);
    chk("done_after_last_wr", 32'(done_cyc), 32'(last_wr + 1));
    chk("busy_at_done", 32'(o_busy), 32'd1);
    tick();
    chk("busy_drop", 32'(o_busy), 32'd0);
    repeat (3) tick();
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("rd_count", 32'(rd_seen), 32'(N));
    chk("wr_count", 32'(wr_seen), 32'(N));
    chk("first_rd_latency", 32'(first_rd), 32'(t0 + 1));
    chk("first_issue_latency", 32'(first_iss), 32'(t0 + 2));
    chk("second_issue_latency", 32'(second_iss), 32'(t0 + 3));
    chk("outstanding_limit", 32'(maxout <= MAXO), 32'd1);
    chk("all_returned", 32'(issued - returned), 32'd0);
    chk("no_missing_write", 32'(exp_wr_q.size()), 32'd0);
    chk("no_error", 32'(o_error), 32'd0);
  endtask

  task automatic chk_all_zero(input string phase);
    chk({phase, "_rd_en"}, 32'(o_node_rd_en), 32'd0);
    chk({phase, "_rd_addr"}, 32'(o_node_rd_addr), 32'd0);
    chk({phase, "_dp_valid"}, 32'(o_dp_valid), 32'd0);
    chk({phase, "_dp_addr"}, 32'(o_dp_node_addr), 32'd0);
    chk({phase, "_dp_data"}, o_dp_data_node, 32'd0);
    chk({phase, "_wr_en"}, 32'(o_delta_wr_en), 32'd0);
    chk({phase, "_wr_addr"}, 32'(o_delta_wr_addr), 32'd0);
    chk({phase, "_wr_data"}, o_delta_wr_data, 32'd0);
    chk({phase, "_done"}, 32'(o_done), 32'd0);
    chk({phase, "_busy"}, 32'(o_busy), 32'd0);
    chk({phase, "_error"}, 32'(o_error), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) act[i] = '0;
    rd_seen = 0; wr_seen = 0; issued = 0; returned = 0; maxout = 0;
    first_rd = -1; first_iss = -1; second_iss = -1;
    done_cnt = 0; done_cyc = -1; last_wr = -1; last_due = 0;

    repeat (2) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_not_busy", 32'(o_busy), 32'd0);

    // Unexpected datapath return while idle
    i_dp_valid = 1'b1;
    i_dp_delta = 32'h1234_5678;
    tick();
    chk("spurious_no_write", 32'(o_delta_wr_en), 32'd0);
    chk("spurious_error", 32'(o_error), 32'd1);

    run(21, 21, 1'b0);
    run(1, 3, 1'b0);
    run(1, 10, 1'b1);
    run(1, 6, 1'b0);
    run(4, 12, 1'b0);

    // Reset in the middle of a run, with requests still in the datapath
    begin_run(21, 21);
    for (int k = 0; k < 500 && issued < 5; k++) tick();
    chk("five_issued", 32'(issued), 32'd5);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrun_reset");
    no_wr = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 200 && dpq.size() > 0; k++) tick();
    repeat (2) tick();
    chk("late_return_error", 32'(o_error), 32'd1);
    chk("abort_no_done", 32'(done_cnt), 32'd0);

    run(2, 8, 1'b0);

`ifdef BP_SCHED_TIMEOUT_EN
    // Datapath never answers: watchdog ends the run
    begin_run(1, 1);
    stall = 1'b1;
    for (int k = 0; k < 400 && done_cnt == 0; k++) tick();
    chk("wd_done", 32'(done_cnt), 32'd1);
    chk("wd_done_cycle", 32'(done_cyc), 32'(t0 + TO + 1));
    chk("wd_error", 32'(o_error), 32'd1);
    chk("wd_no_write", 32'(wr_seen), 32'd0);
    stall = 1'b0;
    dpq.delete();
    repeat (3) tick();
    run(1, 5, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bp_hidden_scheduler.md
# bp_hidden_scheduler

Sequences one time-shared hidden-layer back-propagation datapath across all hidden nodes of a layer. On `i_start` it fetches each node's forward activation from the node RAM, issues it with its node index to the datapath, tracks outstanding requests with an in-order tag FIFO, and writes each returned delta to the hidden-delta RAM at the matching address. It sits between the training controller and the single back-propagation node instance, replacing one instance per hidden node.

## Interface
- `DATA_WIDTH`, 32, IEEE-754 single word width
- `ADDRESS_WIDTH`, 11, RAM address width
- `NUMBER_OF_BACK_NODE`, 32, hidden nodes processed per run (>=1)
- `MAX_OUTSTANDING`, 4, max requests in flight in the datapath (power of two, >=1)
- `TIMEOUT_CYCLES`, 64, watchdog limit (used only with `BP_SCHED_TIMEOUT_EN`)

Ports:
- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `i_start` in 1 — one-cycle run request, honoured only in IDLE
- `o_busy` out 1 — high from the cycle after an accepted start until DONE exits
- `o_done` out 1 — one-cycle pulse when the last delta is written
- `o_error` out 1 — sticky fault flag, cleared by an accepted `i_start`
- `o_node_rd_en` out 1 — node RAM read strobe
- `o_node_rd_addr` out ADDRESS_WIDTH — node index to read
- `i_node_rd_data` in DATA_WIDTH — activation, valid one cycle after `o_node_rd_en`
- `o_dp_valid` out 1 — datapath issue strobe
- `o_dp_node_addr` out ADDRESS_WIDTH — node index accompanying the issue
- `o_dp_data_node` out DATA_WIDTH — activation to datapath
- `i_dp_valid` in 1 — datapath result strobe (in-order)
- `i_dp_delta` in DATA_WIDTH — returned delta
- `o_delta_wr_en` out 1 — delta RAM write strobe
- `o_delta_wr_addr` out ADDRESS_WIDTH — write address (node index)
- `o_delta_wr_data` out DATA_WIDTH — delta written

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: `i_start` -> FETCH, clear read counter, write counter, credit counter, FIFO, `o_error`.
- FETCH: each cycle with credits < MAX_OUTSTANDING, assert `o_node_rd_en` with `o_node_rd_addr` = read counter, increment read counter and credits. When read counter reaches NUMBER_OF_BACK_NODE -> DRAIN.
- Issue: registered read strobe drives `o_dp_valid`; node index pushed to tag FIFO on the same cycle.
- Return: `i_dp_valid` pops FIFO head, registers index and delta, decrements credits, increments write counter.
- Simultaneous fetch and return: credits unchanged.
- DRAIN: waits until write counter = NUMBER_OF_BACK_NODE and final write issued -> DONE.
- DONE: `o_done` high one cycle -> IDLE.
- `i_dp_valid` with FIFO empty: result dropped, no write, `o_error` set.
- `i_start` outside IDLE ignored.
- Counters sized $clog2(NUMBER_OF_BACK_NODE+1); credits $clog2(MAX_OUTSTANDING+1); no wrap occurs in a legal run.

## Timing
- Reset: all outputs 0, state IDLE, FIFO empty; reset mid-run aborts without `o_done`, late datapath returns after reset are treated as unexpected (`o_error`).
- `i_start` at cycle T -> first `o_node_rd_en` at T+1, first `o_dp_valid` at T+2.
- Steady-state throughput one issue per cycle while credits available.
- `i_dp_valid` at cycle R -> `o_delta_wr_en` at R+1.
- Last write at cycle W -> `o_done` at W+1; `o_busy` falls at W+2.

## Configuration
- `BP_SCHED_TIMEOUT_EN` defined: watchdog counts cycles with credits > 0 and no `i_dp_valid`; reaching TIMEOUT_CYCLES sets `o_error`, flushes FIFO and credits, enters DONE (`o_done` still pulses).
- Undefined: no watchdog; a stalled datapath holds DRAIN indefinitely; `o_error` only from unexpected returns.

## Structure
- Shared package `bp_sched_pkg`: state enum type, FLOAT_ONE constant, counter-width helper function.
- One sub-module: `bp_tag_fifo` (synchronous FIFO, depth MAX_OUTSTANDING, width ADDRESS_WIDTH, full/empty flags).

## Test plan
- NUMBER_OF_BACK_NODE=4, fixed 21-cycle datapath model, start -> four issues at T+2..T+5, writes to addresses 0..3 with returned deltas, `o_done` once.
- MAX_OUTSTANDING=2, datapath latency 10 -> never more than 2 issues outstanding, writes 0..31 in order, credits return to 0.
- Return and fetch in same cycle -> credit count unchanged, no lost or duplicate address.
- Spurious `i_dp_valid` in IDLE -> no write, `o_error`=1, cleared by next `i_start`.
- Reset asserted after 5 issues -> all outputs 0 next edge, no `o_done`.
- With `BP_SCHED_TIMEOUT_EN`, TIMEOUT_CYCLES=64, datapath never returns -> `o_error`=1 and `o_done` pulse after 64 idle cycles.
